clkdiv_monitor: RTL and testbench
=================================

Name: clkdiv_monitor

Overview:
- Receiving end of the clock divider's outputs: samples one divided clock (pclk, sclk, bclk or sec_clk) in the master clk domain and measures its period and high time in clk cycles.
- Checks each measured period against an expected value, then reports lock, fault and stuck conditions.
- One instance per divided clock, in the top level next to the divider, for on-board and in-simulation checking.

Parameters:
- CNT_W, 28, width of all cycle counters and measurement outputs.
- EXPECTED_PERIOD, 4, nominal divided-clock period in clk cycles.
- TOLERANCE, 0, allowed absolute deviation from EXPECTED_PERIOD, in cycles.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked (1..15).
- TIMEOUT, 2*EXPECTED_PERIOD+2, cycles without a rising edge before the clock is declared stuck.

Ports:
- clk, input, 1, master clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- div_in, input, 1, divided clock under test; generated in the clk domain, so no synchronizer.
- period, output, CNT_W, last measured period in clk cycles.
- high_time, output, CNT_W, clk cycles div_in was high in the last period.
- period_valid, output, 1, one-cycle pulse when period/high_time update.
- locked, output, 1, LOCK_COUNT consecutive in-tolerance periods seen.
- fault, output, 1, sticky: some period was out of tolerance or a timeout occurred.
- stuck, output, 1, no rising edge within TIMEOUT cycles; cleared by the next rising edge.

Behaviour:
- Reset (rst=1 at posedge) clears everything:
  - period, high_time, period_valid, locked, fault and stuck go to 0.
  - State goes to IDLE; counters and match count go to 0; d_q goes to 0.
- Edge detect: d_q <= div_in every cycle; rise = div_in & ~d_q, combinational in the same cycle.
- State IDLE (waiting for the first edge):
  - On rise: cnt<=1, hcnt<=1, go to MEASURE. No period_valid is produced; the first partial period is never reported.
  - Without rise: tmo increments. When tmo reaches TIMEOUT, stuck<=1 and fault<=1.
- State MEASURE, cycle without rise:
  - cnt<=cnt+1, saturating at all-ones.
  - hcnt<=hcnt+1 if div_in=1, also saturating.
  - When cnt reaches TIMEOUT: stuck<=1, fault<=1, locked<=0, match count<=0, go to IDLE. No period_valid on timeout.
- State MEASURE, cycle with rise:
  - Capture: period<=cnt, high_time<=hcnt, period_valid<=1 (visible the next cycle); then cnt<=1, hcnt<=1.
  - Match rule: match = (cnt >= EXPECTED_PERIOD-TOLERANCE) && (cnt <= EXPECTED_PERIOD+TOLERANCE). The lower bound clamps at 0; compare unsigned at CNT_W+1 bits.
  - On match: match count increments, saturating at LOCK_COUNT. locked<=1 when the incremented count equals LOCK_COUNT, registered on the same edge as period_valid.
  - On mismatch: match count<=0, locked<=0, fault<=1.
- Any rise clears stuck, in either state.
- Measurement convention: if rises occur at cycles t and t+N, then period=N. For a 50% duty /4 clock, period=4 and high_time=2.
- period_valid is high for exactly one cycle per captured edge and 0 at all other times.
- fault clears only on rst.
- Reset mid-measurement discards the partial count; the next rise after reset is treated as a first edge.
- Simultaneous rise and timeout in the same cycle: rise wins. Capture normally; no timeout.
- div_in held constant high or low: same stuck behaviour, because only rising edges count.

Test Plan:
- Drive div_in as a /4 clock (2 high, 2 low) from reset release, EXPECTED_PERIOD=4:
  - period=4 and high_time=2 on every period_valid.
  - First period_valid appears after the second rising edge.
  - locked rises on the 4th period_valid; fault stays 0.
- Same /4 stream, then insert one 5-cycle period (3 high):
  - That capture gives period=5, high_time=3; locked drops with it and fault=1.
  - locked reasserts after 4 more good periods; fault stays 1 until rst.
- Lock on /4, then hold div_in=0:
  - stuck=1, fault=1 and locked=0 once cnt reaches TIMEOUT=10, with no period_valid.
  - Resume toggling: stuck clears on the next rise; the first period_valid comes one period later.
- Instance with EXPECTED_PERIOD=100, TOLERANCE=1 and a 99/100/101-cycle div_in mix: all match and locked asserts. A 98-cycle period sets fault.
- Assert rst for one cycle halfway through a period: all outputs are 0 the next cycle. The next rise produces no period_valid; the following rise reports a correct full period.
- Instance with CNT_W=4 and TIMEOUT=20 (not reachable at this width) with a 20-cycle div_in: cnt saturates, period=15 is captured, fault=1.

Source files
------------

// File: rtl/clkdiv_monitor.sv
// -----------------------------------------------------------------------------
// clkdiv_monitor
//
// Watches one divided clock (generated in the clk domain) and measures the
// distance between consecutive rising edges (period) and the number of cycles
// it was high within that period (high_time). Each completed period is checked
// against EXPECTED_PERIOD +/- TOLERANCE. The monitor reports lock after
// LOCK_COUNT consecutive good periods, a sticky fault on any bad period or
// timeout, and stuck when no rising edge arrives within TIMEOUT cycles.
//
// Ports:
//   clk          master clock, all logic on posedge
//   rst          synchronous active-high reset
//   div_in       divided clock under test (same domain, no synchronizer)
//   period       last measured period in clk cycles
//   high_time    clk cycles div_in was high during the last period
//   period_valid one-cycle pulse when period/high_time update
//   locked       LOCK_COUNT consecutive in-tolerance periods seen
//   fault        sticky: out-of-tolerance period or timeout since reset
//   stuck        no rising edge within TIMEOUT cycles; cleared by next rise
// -----------------------------------------------------------------------------
module clkdiv_monitor #(
    parameter int CNT_W           = 28,
    parameter int EXPECTED_PERIOD = 4,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = 2 * EXPECTED_PERIOD + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic             stuck
);

    // Lower bound clamps at zero so a tolerance wider than the period
    // cannot wrap into a huge unsigned limit.
    localparam int LO_INT = (EXPECTED_PERIOD > TOLERANCE) ? (EXPECTED_PERIOD - TOLERANCE) : 0;
    localparam int HI_INT = EXPECTED_PERIOD + TOLERANCE;
    localparam logic [CNT_W:0]   LO_BOUND = (CNT_W+1)'(LO_INT);
    localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(HI_INT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
    // Timeout comparison is done wide so a TIMEOUT larger than the counter
    // range simply never fires instead of aliasing onto a smaller value.
    localparam int CMP_W = CNT_W + 32;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_reg;
    logic             d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] hcnt_reg;
    logic [CNT_W-1:0] tmo_reg;
    logic [3:0]       match_reg;

    logic             rise;
    logic             match_hit;
    logic             cnt_timeout;
    logic             tmo_timeout;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] hcnt_next;
    logic [CNT_W-1:0] tmo_next;
    logic [3:0]       match_next;

    assign rise        = div_in & ~d_reg;
    assign match_hit   = ({1'b0, cnt_reg} >= LO_BOUND) && ({1'b0, cnt_reg} <= HI_BOUND);
    assign cnt_timeout = (CMP_W'(cnt_reg) == CMP_W'(TIMEOUT));
    assign tmo_timeout = (CMP_W'(tmo_reg) == CMP_W'(TIMEOUT));

    // Saturating increments
    assign cnt_next   = (cnt_reg  == CNT_MAX) ? cnt_reg  : cnt_reg  + CNT_ONE;
    assign hcnt_next  = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_ONE;
    assign tmo_next   = (tmo_reg  == CNT_MAX) ? tmo_reg  : tmo_reg  + CNT_ONE;
    assign match_next = (match_reg == LOCK_N) ? match_reg : match_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            d_reg        <= 1'b0;
            cnt_reg      <= '0;
            hcnt_reg     <= '0;
            tmo_reg      <= '0;
            match_reg    <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
            stuck        <= 1'b0;
        end else begin
            d_reg        <= div_in;
            period_valid <= 1'b0;
            if (rise) begin
                stuck <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        // First edge only starts a measurement; the partial
                        // period before it is never reported.
                        cnt_reg   <= CNT_ONE;
                        hcnt_reg  <= CNT_ONE;
                        tmo_reg   <= '0;
                        state_reg <= MEASURE;
                    end else begin
                        tmo_reg <= tmo_next;
                        if (tmo_timeout) begin
                            stuck <= 1'b1;
                            fault <= 1'b1;
                        end
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        // A rise takes priority over a coincident timeout.
                        period       <= cnt_reg;
                        high_time    <= hcnt_reg;
                        period_valid <= 1'b1;
                        cnt_reg      <= CNT_ONE;
                        hcnt_reg     <= CNT_ONE;
                        if (match_hit) begin
                            match_reg <= match_next;
                            if (match_next == LOCK_N) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match_reg <= '0;
                            locked    <= 1'b0;
                            fault     <= 1'b1;
                        end
                    end else if (cnt_timeout) begin
                        stuck     <= 1'b1;
                        fault     <= 1'b1;
                        locked    <= 1'b0;
                        match_reg <= '0;
                        tmo_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (div_in) begin
                            hcnt_reg <= hcnt_next;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_monitor
//
// Directed bench for clkdiv_monitor. Three instances:
//   u0: defaults (EXPECTED_PERIOD=4, TOLERANCE=0, LOCK_COUNT=4, TIMEOUT=10)
//   u1: EXPECTED_PERIOD=100, TOLERANCE=1
//   u2: CNT_W=4, TIMEOUT=20 (counter saturates before timeout)
// One instance is driven at a time (sel); expected captures are pushed to a
// scoreboard when the completing rising edge is driven and popped when
// period_valid is observed.
// -----------------------------------------------------------------------------
module tb_clkdiv_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d0 = 1'b0, d1 = 1'b0, d2 = 1'b0;

    logic [27:0] per0, ht0, per1, ht1;
    logic [3:0]  per2, ht2;
    logic pv0, pv1, pv2, lk0, lk1, lk2, ft0, ft1, ft2, st0, st1, st2;

    always #5 clk = ~clk;

    clkdiv_monitor u0 (
        .clk(clk), .rst(rst), .div_in(d0),
        .period(per0), .high_time(ht0), .period_valid(pv0),
        .locked(lk0), .fault(ft0), .stuck(st0)
    );

    clkdiv_monitor #(.EXPECTED_PERIOD(100), .TOLERANCE(1)) u1 (
        .clk(clk), .rst(rst), .div_in(d1),
        .period(per1), .high_time(ht1), .period_valid(pv1),
        .locked(lk1), .fault(ft1), .stuck(st1)
    );

    clkdiv_monitor #(.CNT_W(4), .TIMEOUT(20)) u2 (
        .clk(clk), .rst(rst), .div_in(d2),
        .period(per2), .high_time(ht2), .period_valid(pv2),
        .locked(lk2), .fault(ft2), .stuck(st2)
    );

    int sel = 0;
    logic [27:0] obs_per, obs_ht;
    logic obs_pv, obs_lk, obs_ft, obs_st;

    always_comb begin
        obs_per = '0;
        obs_ht  = '0;
        obs_pv  = 1'b0;
        obs_lk  = 1'b0;
        obs_ft  = 1'b0;
        obs_st  = 1'b0;
        case (sel)
            0: begin
                obs_per = per0; obs_ht = ht0; obs_pv = pv0;
                obs_lk = lk0; obs_ft = ft0; obs_st = st0;
            end
            1: begin
                obs_per = per1; obs_ht = ht1; obs_pv = pv1;
                obs_lk = lk1; obs_ft = ft1; obs_st = st1;
            end
            default: begin
                obs_per = {24'd0, per2}; obs_ht = {24'd0, ht2}; obs_pv = pv2;
                obs_lk = lk2; obs_ft = ft2; obs_st = st2;
            end
        endcase
    end

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk cycle of stimulus on the selected instance, then check the
    // capture pulse against the scoreboard.
    task automatic cyc(input logic d);
        exp_t e;
        case (sel)
            0:       d0 = d;
            1:       d1 = d;
            default: d2 = d;
        endcase
        @(posedge clk);
        #1;
        chk("period_valid", {31'd0, obs_pv}, {31'd0, (sb.size() > 0)});
        if (obs_pv && sb.size() > 0) begin
            e = sb.pop_front();
            chk("period", {4'd0, obs_per}, e.p);
            chk("high_time", {4'd0, obs_ht}, e.h);
            $display("capture sel=%0d period=%0d high_time=%0d locked=%0b fault=%0b",
                     sel, obs_per, obs_ht, obs_lk, obs_ft);
        end else begin
            sb.delete();
        end
    endtask

    // One div_in period: hi cycles high (first is the rising edge), lo cycles
    // low. The rising edge completes the previous period; if cap is set its
    // expected values are ep/eh. locked/fault are checked right after the edge.
    task automatic dp(input int hi, input int lo, input bit cap, input int ep, input int eh,
                      input logic elock, input logic efault);
        exp_t e;
        if (cap) begin
            e.p = ep;
            e.h = eh;
            sb.push_back(e);
        end
        cyc(1'b1);
        chk("locked", {31'd0, obs_lk}, {31'd0, elock});
        chk("fault", {31'd0, obs_ft}, {31'd0, efault});
        chk("stuck_after_rise", {31'd0, obs_st}, 32'd0);
        for (int i = 1; i < hi; i++) cyc(1'b1);
        for (int i = 0; i < lo; i++) cyc(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        d0 = 1'b0;
        d1 = 1'b0;
        d2 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("rst_period", {4'd0, obs_per}, 32'd0);
        chk("rst_high_time", {4'd0, obs_ht}, 32'd0);
        chk("rst_period_valid", {31'd0, obs_pv}, 32'd0);
        chk("rst_locked", {31'd0, obs_lk}, 32'd0);
        chk("rst_fault", {31'd0, obs_ft}, 32'd0);
        chk("rst_stuck", {31'd0, obs_st}, 32'd0);
        $display("reset sel=%0d", sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // /4 stream from reset release: lock on the 4th capture
        sel = 0;
        do_reset();
        dp(2, 2, 0, 0, 0, 1'b0, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b1, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b1, 1'b0);

        // One 5-cycle period (3 high): drops lock, sets fault, relock after 4
        dp(3, 2, 1, 4, 2, 1'b1, 1'b0);
        dp(2, 2, 1, 5, 3, 1'b0, 1'b1);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b1);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b1);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b1);
        dp(2, 2, 1, 4, 2, 1'b1, 1'b1);

        // Hold low: stuck when cnt reaches TIMEOUT=10, i.e. 10 cycles after the rise
        for (int i = 0; i < 6; i++) cyc(1'b0);
        chk("stuck_before_timeout", {31'd0, obs_st}, 32'd0);
        chk("locked_before_timeout", {31'd0, obs_lk}, 32'd1);
        cyc(1'b0);
        chk("stuck_at_timeout", {31'd0, obs_st}, 32'd1);
        chk("locked_at_timeout", {31'd0, obs_lk}, 32'd0);
        chk("fault_at_timeout", {31'd0, obs_ft}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        chk("stuck_held", {31'd0, obs_st}, 32'd1);
        dp(2, 2, 0, 0, 0, 1'b0, 1'b1);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b1);

        // EXPECTED_PERIOD=100, TOLERANCE=1: 99/100/101 all match, 98 faults
        sel = 1;
        do_reset();
        dp(50, 50, 0, 0, 0, 1'b0, 1'b0);
        dp(50, 49, 1, 100, 50, 1'b0, 1'b0);
        dp(50, 51, 1, 99, 50, 1'b0, 1'b0);
        dp(50, 50, 1, 101, 50, 1'b0, 1'b0);
        dp(50, 49, 1, 100, 50, 1'b1, 1'b0);
        dp(50, 48, 1, 99, 50, 1'b1, 1'b0);
        dp(50, 50, 1, 98, 50, 1'b0, 1'b1);

        // Reset halfway through a period discards it
        sel = 0;
        do_reset();
        dp(2, 2, 0, 0, 0, 1'b0, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b0);
        dp(2, 0, 1, 4, 2, 1'b0, 1'b0);
        do_reset();
        dp(2, 2, 0, 0, 0, 1'b0, 1'b0);
        dp(2, 2, 1, 4, 2, 1'b0, 1'b0);

        // CNT_W=4, unreachable TIMEOUT=20: 20-cycle period saturates to 15
        sel = 2;
        do_reset();
        dp(10, 10, 0, 0, 0, 1'b0, 1'b0);
        chk("sat_no_stuck", {31'd0, obs_st}, 32'd0);
        dp(10, 10, 1, 15, 10, 1'b0, 1'b1);

        // Timeout from IDLE with no edge at all after reset
        sel = 0;
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0);
        chk("idle_stuck_before", {31'd0, obs_st}, 32'd0);
        cyc(1'b0);
        chk("idle_stuck", {31'd0, obs_st}, 32'd1);
        chk("idle_fault", {31'd0, obs_ft}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
